// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE,
    CHECK,
    ERR
  } state_e;

  localparam logic [6:0]  OPCODE_HALT    = 7'b0000001;
  localparam logic [6:0]  OPCODE_LOAD    = 7'b1111111;
  // A word consisting of the bare halt opcode terminates the load session.
  localparam logic [31:0] HALT_WORD      = {25'd0, OPCODE_HALT};
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_assembler.sv
// Byte index counter and little-endian packing register for one instruction word.
// word/word_full are combinational views that include the byte accepted this cycle,
// so the owner can capture a complete word on the same edge as its last byte.
module word_assembler
  import loader_pkg::*;
#(
  parameter int unsigned WIDTH = BYTES_PER_WORD * 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic [7:0]       byte_in,
  input  logic             clear,
  output logic [WIDTH-1:0] word,
  output logic             word_full
);

  localparam int unsigned NumBytes = WIDTH / 8;
  localparam int unsigned IdxWidth = $clog2(NumBytes);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumBytes - 1);

  logic [IdxWidth-1:0] idx_q;
  logic [WIDTH-1:0]    word_q;

  // Merge the incoming byte into its little-endian lane.
  always_comb begin
    word = word_q;
    if (accept) begin
      word[{idx_q, 3'b000} +: 8] = byte_in;
    end
    word_full = accept && (idx_q == LastIdx);
  end

  // Packing register and byte index; index wraps after the last lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clear) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (accept) begin
      word_q <= word;
      idx_q  <= (idx_q == LastIdx) ? '0 : idx_q + IdxWidth'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Byte-serial loader that fills the CPU instruction memory and holds the CPU in reset
// until the session completes. Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte; without it the error output is tied low.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  loading,
  output logic                  done,
  output logic                  cpu_hold,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH:0]   CountOne = 1;
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  byte_ready_q, mem_wen_q, loading_q, done_q, cpu_hold_q;

  logic             asm_accept, asm_clear, asm_full;
  logic [WIDTH-1:0] asm_word;

  // Only data bytes in LOAD feed the packer; the checksum byte does not.
  assign asm_accept = byte_valid && byte_ready_q && (state_q == LOAD);

  word_assembler #(
    .WIDTH (WIDTH)
  ) u_word_assembler (
    .clk       (clk),
    .rst       (rst),
    .accept    (asm_accept),
    .byte_in   (byte_in),
    .clear     (asm_clear),
    .word      (asm_word),
    .word_full (asm_full)
  );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       error_q;
`endif

  // Next-state and datapath updates for the load session.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    count_d   = count_q;
    asm_clear = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (load_start) begin
          state_d   = LOAD;
          addr_d    = '0;
          count_d   = '0;
          asm_clear = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end
      LOAD: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (asm_accept) csum_d = csum_q ^ byte_in;
`endif
        if (asm_full) begin
          state_d = WRITE;
          wdata_d = asm_word;
          count_d = count_q + CountOne;
        end
      end
      WRITE: begin
        // Address never wraps: the write to the last entry always ends the session.
        if ((wdata_q == WIDTH'(HALT_WORD)) || (addr_q == LastAddr)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = LOAD;
          addr_d  = addr_q + AddrOne;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (byte_valid && byte_ready_q) begin
          state_d = (byte_in == csum_q) ? DONE : ERR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      count_q      <= '0;
      byte_ready_q <= 1'b0;
      mem_wen_q    <= 1'b0;
      loading_q    <= 1'b0;
      done_q       <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      count_q      <= count_d;
      byte_ready_q <= (state_d == LOAD) || (state_d == CHECK);
      mem_wen_q    <= (state_d == WRITE);
      loading_q    <= (state_d == LOAD) || (state_d == WRITE) || (state_d == CHECK);
      done_q       <= (state_d == DONE);
      cpu_hold_q   <= (state_d != DONE);
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  // Running checksum and registered error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q  <= '0;
      error_q <= 1'b0;
    end else begin
      csum_q  <= csum_d;
      error_q <= (state_d == ERR);
    end
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign byte_ready = byte_ready_q;
  assign mem_wen    = mem_wen_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = count_q;
  assign loading    = loading_q;
  assign done       = done_q;
  assign cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: session-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized sessions.
// Follows PROGRAM_LOADER_CHECKSUM_EN the same way the design does.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst, load_start, byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready, mem_wen, loading, done, cpu_hold, error;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [5:0]  word_count;

  int vectors = 0;
  int miscompares = 0;

  program_loader #(
    .ADDR_WIDTH (5),
    .WIDTH      (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .word_count (word_count),
    .loading    (loading),
    .done       (done),
    .cpu_hold   (cpu_hold),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (session level) ----------------
  bit          m_active, m_wen, m_ready, m_done, m_err, m_check;
  logic [4:0]  m_addr;
  logic [31:0] m_wdata;
  int          m_count;
  logic [7:0]  m_csum;
  logic [7:0]  m_bytes[$];

  // Observed writes, for the literal checks of directed scenarios.
  logic [4:0]  log_addr[$];
  logic [31:0] log_data[$];

  task automatic model_reset();
    m_active = 0; m_wen = 0; m_ready = 0; m_done = 0; m_err = 0; m_check = 0;
    m_addr = '0; m_wdata = '0; m_count = 0; m_csum = '0;
    m_bytes.delete();
  endtask

  // Advance the model across the coming clock edge using the inputs now applied.
  task automatic model_step();
    logic acc;
    acc = byte_valid && m_ready;
    if (!m_active) begin
      if (load_start) begin
        m_active = 1; m_ready = 1; m_done = 0; m_err = 0; m_check = 0;
        m_addr = '0; m_count = 0; m_csum = '0;
        m_bytes.delete();
      end
    end else if (m_wen) begin
      m_wen = 0;
      if (m_wdata == 32'h1 || m_addr == 5'd31) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        m_check = 1; m_ready = 1;
`else
        m_active = 0; m_ready = 0; m_done = 1;
`endif
      end else begin
        m_addr  = m_addr + 5'd1;
        m_ready = 1;
      end
    end else if (acc) begin
      if (m_check) begin
        m_check = 0; m_active = 0; m_ready = 0;
        if (byte_in == m_csum) m_done = 1;
        else m_err = 1;
      end else begin
        m_bytes.push_back(byte_in);
        m_csum = m_csum ^ byte_in;
        if (m_bytes.size() == 4) begin
          m_wdata = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          m_bytes.delete();
          m_wen = 1; m_ready = 0;
          m_count++;
        end
      end
    end
  endtask

  // Compare every cycle on the falling edge, then step the model.
  always @(negedge clk) begin
    if (rst) model_reset();
    check("byte_ready", byte_ready, m_ready);
    check("mem_wen", mem_wen, m_wen);
    check("mem_addr", mem_addr, m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
    check("word_count", word_count, m_count);
    check("loading", loading, m_active);
    check("done", done, m_done);
    check("cpu_hold", cpu_hold, !m_done);
    check("error", error, m_err);
    if (mem_wen === 1'b1) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
    if (!rst) model_step();
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0]  tx[$];
  logic [31:0] words[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    log_addr.delete();
    log_data.delete();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic maybe_ls(input int ls_pct);
    if (ls_pct > 0 && $urandom_range(99, 0) < ls_pct) load_start = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max, input int ls_pct);
    int n;
    int gaps;
    gaps = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
    repeat (gaps) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      tick();
    end
    byte_valid = 1'b1;
    byte_in    = b;
    n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      maybe_ls(ls_pct);
      tick();
      load_start = 1'b0;
      n++;
    end
    check("handshake_timeout", n < 50, 1);
    maybe_ls(ls_pct);
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_tx(input int gap_max, input int ls_pct);
    foreach (tx[i]) send_byte(tx[i], gap_max, ls_pct);
    byte_valid = 1'b0;
  endtask

  // Little-endian bytes of every word, plus the checksum byte when enabled.
  task automatic build_tx(input bit bad_csum);
    logic [7:0] cs;
    logic [31:0] w;
    cs = '0;
    tx.delete();
    foreach (words[i]) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        tx.push_back(w[8*k +: 8]);
        cs = cs ^ w[8*k +: 8];
      end
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    tx.push_back(bad_csum ? (cs ^ 8'h01) : cs);
`else
    if (bad_csum) cs = '0;
`endif
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < 200) begin
      tick();
      n++;
    end
    check("session_end_timeout", n < 200, 1);
  endtask

  task automatic run_words(input int gap_max, input int ls_pct, input bit bad_csum);
    build_tx(bad_csum);
    pulse_start();
    send_tx(gap_max, ls_pct);
    wait_end();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    logic [31:0] w;
    rst = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    model_reset();
    repeat (3) tick();
    check("rst_byte_ready", byte_ready, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_word_count", word_count, 0);
    check("rst_loading", loading, 0);
    check("rst_done", done, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_error", error, 0);
    rst = 1'b0;
    tick();

    // Basic load: FF 70 00 00 01 00 00 00.
    words = '{32'h0000_70FF, 32'h0000_0001};
    run_words(1, 0, 0);
    check("basic_nwrites", log_data.size(), 2);
    check("basic_addr0", log_addr[0], 0);
    check("basic_data0", log_data[0], 32'h0000_70FF);
    check("basic_addr1", log_addr[1], 1);
    check("basic_data1", log_data[1], 32'h0000_0001);
    check("basic_done", done, 1);
    check("basic_count", word_count, 2);
    check("basic_hold", cpu_hold, 0);

    // Backpressure: valid held continuously across write cycles.
    words = '{32'h0403_0201, 32'h0807_0605, 32'h0000_0001};
    run_words(0, 0, 0);
    check("bp_nwrites", log_data.size(), 3);
    check("bp_data0", log_data[0], 32'h0403_0201);
    check("bp_data1", log_data[1], 32'h0807_0605);
    check("bp_data2", log_data[2], 32'h0000_0001);

    // Full memory: 32 non-halt words end at the last address.
    words.delete();
    for (int n = 0; n < 32; n++) words.push_back(32'h33 + n);
    run_words(1, 0, 0);
    check("full_nwrites", log_data.size(), 32);
    check("full_last_addr", log_addr[31], 31);
    check("full_last_data", log_data[31], 32'h0000_0052);
    check("full_count", word_count, 32);
    check("full_done", done, 1);
    byte_valid = 1'b1; byte_in = 8'h5A;
    repeat (5) tick();
    byte_valid = 1'b0;
    check("full_no_33rd", log_data.size(), 32);

    // Reset mid-word discards the partial word.
    pulse_start();
    tx = '{8'h11, 8'h22};
    send_tx(0, 0);
    rst = 1'b1;
    #1;
    check("midrst_byte_ready", byte_ready, 0);
    check("midrst_loading", loading, 0);
    check("midrst_cpu_hold", cpu_hold, 1);
    check("midrst_mem_wdata", mem_wdata, 0);
    tick();
    rst = 1'b0;
    tick();
    words = '{32'hDDCC_BBAA, 32'h0000_0001};
    run_words(0, 0, 0);
    check("midrst_addr0", log_addr[0], 0);
    check("midrst_data0", log_data[0], 32'hDDCC_BBAA);

    // load_start during LOAD/WRITE is ignored; addresses keep counting.
    words = '{32'h1111_0010, 32'h2222_0020, 32'h3333_0030, 32'h0000_0001};
    run_words(1, 40, 0);
    check("restart_nwrites", log_data.size(), 4);
    check("restart_addr3", log_addr[3], 3);
    check("restart_count", word_count, 4);

    // Restart from DONE with a byte already presented: it must wait for LOAD.
    log_addr.delete(); log_data.delete();
    load_start = 1'b1; byte_valid = 1'b1; byte_in = 8'h01;
    tick();
    load_start = 1'b0;
    check("restart_addr_clr", mem_addr, 0);
    check("restart_count_clr", word_count, 0);
    check("restart_hold", cpu_hold, 1);
    check("restart_done_clr", done, 0);
    words = '{32'h0000_0001};
    build_tx(0);
    send_tx(0, 0);
    wait_end();
    check("restart_one_write", log_data.size(), 1);
    check("restart_halt_data", log_data[0], 32'h0000_0001);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Literal checksum bytes for the basic image.
    pulse_start();
    tx = '{8'hFF, 8'h70, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h8E};
    send_tx(0, 0);
    wait_end();
    check("csum_ok_done", done, 1);
    check("csum_ok_error", error, 0);
    pulse_start();
    tx = '{8'hFF, 8'h70, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h8F};
    send_tx(0, 0);
    wait_end();
    check("csum_bad_error", error, 1);
    check("csum_bad_done", done, 0);
    check("csum_bad_hold", cpu_hold, 1);
`endif

    // Randomized sessions.
    for (int s = 0; s < 10; s++) begin
      nw = ($urandom_range(7, 0) == 0) ? 32 : $urandom_range(8, 1);
      words.delete();
      for (int i = 0; i < nw; i++) begin
        w = $urandom;
        if (w == 32'h1) w = 32'h2;
        if (i == nw - 1 && nw < 32) w = 32'h1;
        words.push_back(w);
      end
      run_words(2, 10, $urandom_range(2, 0) == 0);
      check("rand_nwrites", log_data.size(), nw);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
